// File: rtl/cntr_chk_pkg.sv
// Shared types and default sizing for the counter sequence checker.
// The optional automatic resync-after-fault behaviour is enabled by CNTR_CHK_RESYNC_EN.
package cntr_chk_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } chk_state_t;

    localparam int CNTR_CHK_W           = 3;
    localparam int CNTR_CHK_LOCK_CYCLES = 2;
    localparam int CNTR_CHK_ERR_CNT_W   = 8;
    // Good-run counter must hold LOCK_CYCLES up to 15.
    localparam int GOOD_RUN_W           = 4;

endpackage

// File: rtl/cntr_chk_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear (clear beats increment).
module cntr_chk_sat_cnt #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [N-1:0] cnt
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {N{1'b0}};
        end else if (inc && (cnt_q != {N{1'b1}})) begin
            cnt_d = cnt_q + N'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cntr_seq_checker.sv
// Lockstep monitor for a free-running up-counter: predicts each value from the previous
// sample and enable, flags deviations. Define CNTR_CHK_RESYNC_EN to relock after a fault.
module cntr_seq_checker
    import cntr_chk_pkg::*;
#(
    parameter int W           = CNTR_CHK_W,
    parameter int LOCK_CYCLES = CNTR_CHK_LOCK_CYCLES,
    parameter int ERR_CNT_W   = CNTR_CHK_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 enbl,
    input  logic [W-1:0]         cnt_i,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 wrap,
    output logic [W-1:0]         exp_o
);

    chk_state_t            state_q, state_d;
    logic [W-1:0]          prev_cnt_q, prev_cnt_d;
    logic                  prev_en_q, prev_en_d;
    logic                  hist_vld_q, hist_vld_d;
    logic [W-1:0]          exp_s;
    logic                  cmp_vld_s, match_s, miss_s;
    logic [GOOD_RUN_W-1:0] good_run_s;
    logic                  run_inc_s, run_clr_s, err_inc_s;
    logic                  locked_q, locked_d, err_q, err_d, wrap_q, wrap_d;
    logic [W-1:0]          exp_q, exp_d;

    always_comb begin
        prev_cnt_d = rst_ ? {W{1'b0}} : cnt_i;
        prev_en_d  = rst_ ? 1'b0 : enbl;
        hist_vld_d = ~rst_;
        exp_s      = prev_cnt_q + W'(prev_en_q);
        cmp_vld_s  = hist_vld_q & ~rst_;
        match_s    = cmp_vld_s & (cnt_i == exp_s);
        miss_s     = cmp_vld_s & (cnt_i != exp_s);
        run_inc_s  = (state_q == ACQ) & match_s;
        run_clr_s  = rst_ | (state_q != ACQ) | miss_s;
        err_inc_s  = (state_q == LOCK) & miss_s;
    end

    always_ff @(posedge clk) begin
        prev_cnt_q <= prev_cnt_d;
        prev_en_q  <= prev_en_d;
        hist_vld_q <= hist_vld_d;
    end

    cntr_chk_sat_cnt #(.N(GOOD_RUN_W)) u_good_run (
        .clk (clk),
        .clr (run_clr_s),
        .inc (run_inc_s),
        .cnt (good_run_s)
    );

    cntr_chk_sat_cnt #(.N(ERR_CNT_W)) u_err_cnt (
        .clk (clk),
        .clr (rst_),
        .inc (err_inc_s),
        .cnt (err_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rst_) begin
            state_d = ACQ;
        end else begin
            case (state_q)
                ACQ: begin
                    if (good_run_s >= GOOD_RUN_W'(LOCK_CYCLES)) begin
                        state_d = LOCK;
                    end else begin
                        state_d = ACQ;
                    end
                end
                LOCK: begin
                    if (miss_s) begin
                        state_d = FAULT;
                    end else begin
                        state_d = LOCK;
                    end
                end
                FAULT: begin
`ifdef CNTR_CHK_RESYNC_EN
                    state_d = ACQ;
`else
                    state_d = FAULT;
`endif
                end
                default: state_d = ACQ;
            endcase
        end
    end

    always_comb begin
        locked_d = (state_d == LOCK);
        err_d    = err_inc_s;
        // A legal wrap is a matching sample of 0 that followed max-value with enable.
        wrap_d   = (state_q == LOCK) & match_s & prev_en_q
                   & (prev_cnt_q == {W{1'b1}}) & (cnt_i == {W{1'b0}});
        exp_d    = cnt_i + W'(enbl);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            exp_q    <= {W{1'b0}};
        end else begin
            locked_q <= locked_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
            exp_q    <= exp_d;
        end
    end

    assign locked = locked_q;
    assign err    = err_q;
    assign wrap   = wrap_q;
    assign exp_o  = exp_q;

endmodule

// File: tb/tb_cntr_seq_checker.sv
// Self-checking bench for cntr_seq_checker: directed scenarios followed by randomized
// counting with injected faults and resets, checked against a behavioural model.
module tb_cntr_seq_checker;

    localparam int LC   = 2;
    localparam int MAXV = 7;
    localparam int M_ACQ = 0, M_LOCK = 1, M_FAULT = 2;

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       enbl = 1'b0;
    logic [2:0] cnt_i = 3'd0;
    logic       locked, err, wrap, locked2, err2, wrap2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    logic [2:0] exp_o, exp_o2;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int m_mode, m_run, m_errs, m_pc;
    bit m_have, m_pe;
    bit e_locked, e_err, e_wrap;
    int e_exp;
    int cur;

    cntr_seq_checker #(.W(3), .LOCK_CYCLES(LC), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_(rst_), .enbl(enbl), .cnt_i(cnt_i),
        .locked(locked), .err(err), .err_cnt(err_cnt), .wrap(wrap), .exp_o(exp_o)
    );

    cntr_seq_checker #(.W(3), .LOCK_CYCLES(LC), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_(rst_), .enbl(enbl), .cnt_i(cnt_i),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2), .wrap(wrap2), .exp_o(exp_o2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model(input int c, input bit e, input bit r);
        bit hit;
        int old_run;
        if (r) begin
            m_mode = M_ACQ; m_run = 0; m_have = 0; m_errs = 0; m_pc = 0; m_pe = 0;
            e_locked = 0; e_err = 0; e_wrap = 0; e_exp = 0;
            return;
        end
        hit = m_have && (c == (m_pc + m_pe) % (MAXV + 1));
        e_err = 0;
        e_wrap = 0;
        case (m_mode)
            M_ACQ: begin
                old_run = m_run;
                if (m_have) m_run = hit ? m_run + 1 : 0;
                if (old_run >= LC) begin
                    m_mode = M_LOCK;
                    m_run = 0;
                end
            end
            M_LOCK: begin
                if (!hit) begin
                    e_err = 1;
                    m_errs++;
                    m_mode = M_FAULT;
                end else if (m_pc == MAXV && m_pe && c == 0) begin
                    e_wrap = 1;
                end
            end
            default: begin
`ifdef CNTR_CHK_RESYNC_EN
                m_mode = M_ACQ;
                m_run = 0;
`endif
            end
        endcase
        m_have = 1;
        m_pc = c;
        m_pe = e;
        e_exp = (c + e) % (MAXV + 1);
        e_locked = (m_mode == M_LOCK);
    endtask

    task automatic step(input int c, input bit e, input bit r);
        @(negedge clk);
        cnt_i = 3'(c);
        enbl = e;
        rst_ = r;
        @(posedge clk);
        model(c, e, r);
        #1;
        chk("locked", {31'd0, locked}, {31'd0, e_locked});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("wrap", {31'd0, wrap}, {31'd0, e_wrap});
        chk("err_cnt", {24'd0, err_cnt}, (m_errs > 255) ? 32'd255 : 32'(m_errs));
        chk("err_cnt_w2", {30'd0, err_cnt2}, (m_errs > 3) ? 32'd3 : 32'(m_errs));
        chk("locked_w2", {31'd0, locked2}, {31'd0, e_locked});
        if (e_locked) chk("exp_o", {29'd0, exp_o}, 32'(e_exp));
    endtask

    task automatic good(input int n, input bit e);
        for (int i = 0; i < n; i++) begin
            step(cur, e, 1'b0);
            cur = (cur + e) % (MAXV + 1);
        end
    endtask

    task automatic skip();
        int s;
        s = (cur + 1) % (MAXV + 1);
        step(s, 1'b1, 1'b0);
        cur = (s + 1) % (MAXV + 1);
    endtask

    initial begin
        int c;
        bit e, r;
        // reset state
        step(0, 1'b0, 1'b1);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_exp_o", {29'd0, exp_o}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // 1: acquire lock on 0,1,2,3
        cur = 0;
        good(4, 1'b1);
        chk("t1_locked", {31'd0, locked}, 32'd1);

        // 2: wrap 7 -> 0
        good(4, 1'b1);
        good(1, 1'b1);
        chk("t2_wrap", {31'd0, wrap}, 32'd1);
        good(1, 1'b1);
        chk("t2_wrap_once", {31'd0, wrap}, 32'd0);
        chk("t2_err_cnt", {24'd0, err_cnt}, 32'd0);

        // 3: hold with enable low
        good(3, 1'b1);
        good(4, 1'b0);
        chk("t3_locked", {31'd0, locked}, 32'd1);
        chk("t3_err", {31'd0, err}, 32'd0);
        good(1, 1'b1);

        // 4: skip 2 -> 4
        good(5, 1'b1);
        skip();
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_err_cnt", {24'd0, err_cnt}, 32'd1);
        chk("t4_locked", {31'd0, locked}, 32'd0);
        good(6, 1'b1);
        chk("t4_err_after", {31'd0, err}, 32'd0);
`ifdef CNTR_CHK_RESYNC_EN
        chk("t4_relock", {31'd0, locked}, 32'd1);
`else
        chk("t4_sticky", {31'd0, locked}, 32'd0);
`endif

        // 5: repeated skips, narrow counter saturates
        step(0, 1'b0, 1'b1);
        cur = 0;
        for (int k = 0; k < 5; k++) begin
            good(6, 1'b1);
            skip();
        end
        good(2, 1'b1);
`ifdef CNTR_CHK_RESYNC_EN
        chk("t5_sat", {30'd0, err_cnt2}, 32'd3);
`else
        chk("t5_sat", {30'd0, err_cnt2}, 32'd1);
`endif

        // 6: reset concurrent with a mismatch
        step(0, 1'b0, 1'b1);
        cur = 0;
        good(5, 1'b1);
        chk("t6_pre_locked", {31'd0, locked}, 32'd1);
        step((cur + 3) % (MAXV + 1), 1'b1, 1'b1);
        chk("t6_err", {31'd0, err}, 32'd0);
        chk("t6_locked", {31'd0, locked}, 32'd0);
        chk("t6_err_cnt", {24'd0, err_cnt}, 32'd0);
        cur = 0;

        // randomized counting with faults and occasional resets
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            e = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, MAXV)) : cur;
            step(c, e, r);
            cur = (c + e) % (MAXV + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
